// File: rtl/parking_gate_if.sv
// Signal bundle between the gate controller and its environment: raw lane
// sensors and occupancy-counter status in, barrier commands and counter
// pulses out.
interface parking_gate_if;
    logic entry_sensor;
    logic exit_sensor;
    logic full_signal;
    logic empty_signal;
    logic entry_gate_open;
    logic exit_gate_open;
    logic entry_denied;
    logic car_arrival;
    logic car_departure;

    // Controller side: consumes sensors and counter status, drives gates and pulses.
    modport master (
        input  entry_sensor, exit_sensor, full_signal, empty_signal,
        output entry_gate_open, exit_gate_open, entry_denied,
               car_arrival, car_departure
    );

    // Environment side: lane sensors, occupancy counter and observers.
    modport slave (
        output entry_sensor, exit_sensor, full_signal, empty_signal,
        input  entry_gate_open, exit_gate_open, entry_denied,
               car_arrival, car_departure
    );
endinterface

// File: rtl/parking_gate_controller.sv
// Entry/exit barrier controller for a car park. Each raw lane sensor is
// synchronized and debounced, then drives its own barrier FSM. Entry is
// refused while the occupancy counter reports full; exit is never blocked.
// Arrival/departure pulses feed the occupancy counter and never coincide.
module parking_gate_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,  // legal range 2..255
    parameter int unsigned CNT_W           = 8   // must hold DEBOUNCE_CYCLES-1
) (
    input  logic           clock,
    input  logic           reset,
    parking_gate_if.master gate
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        E_IDLE = 2'd0,
        E_OPEN = 2'd1,
        E_DENY = 2'd2
    } entry_state_t;

    typedef enum logic {
        X_IDLE = 1'b0,
        X_OPEN = 1'b1
    } exit_state_t;

    // Lane 0 is the entry sensor, lane 1 the exit sensor.
    logic [1:0] raw_sensor;
    logic [1:0] deb_level;
    logic       deb_entry;
    logic       deb_exit;

    // empty_signal is status only; exits proceed regardless.
    logic       unused_empty;

    assign raw_sensor   = {gate.exit_sensor, gate.entry_sensor};
    assign deb_entry    = deb_level[0];
    assign deb_exit     = deb_level[1];
    assign unused_empty = gate.empty_signal;

    // ------------------------------------------------------------------
    // Per-lane synchronizer and debouncer
    // ------------------------------------------------------------------
    for (genvar g = 0; g < 2; g++) begin : g_lane
        logic             sync1_q;
        logic             sync2_q;
        logic             deb_q;
        logic             deb_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;

        // Two-flop synchronizer for the asynchronous raw sensor.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
            end else begin
                // NOTE: non-blocking so sync2_q takes the previous sync1_q,
                // giving two real flop stages instead of a single wire-through.
                sync1_q <= raw_sensor[g];
                sync2_q <= sync1_q;
            end
        end

        // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
        always_comb begin
            // NOTE: defaults first so every path assigns both outputs and no
            // latch is inferred.
            deb_d = deb_q;
            cnt_d = cnt_q;
            if (sync2_q == deb_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                deb_d = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Debounced level and run-length counter registers.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                deb_q <= 1'b0;
                cnt_q <= '0;
            end else begin
                deb_q <= deb_d;
                cnt_q <= cnt_d;
            end
        end

        assign deb_level[g] = deb_q;
    end

    // ------------------------------------------------------------------
    // Entry barrier FSM
    // ------------------------------------------------------------------
    entry_state_t entry_state_q;
    entry_state_t entry_state_d;
    logic         entry_open;
    logic         entry_deny;
    logic         arrival_req;

    // Entry FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            entry_state_q <= E_IDLE;
        end else begin
            entry_state_q <= entry_state_d;
        end
    end

    // Entry next state: full_signal is consulted only when a car first arrives.
    always_comb begin
        entry_state_d = entry_state_q;
        unique case (entry_state_q)
            E_IDLE: begin
                if (deb_entry) begin
                    entry_state_d = gate.full_signal ? E_DENY : E_OPEN;
                end
            end
            E_OPEN: begin
                if (!deb_entry) begin
                    entry_state_d = E_IDLE;
                end
            end
            E_DENY: begin
                if (!deb_entry) begin
                    entry_state_d = E_IDLE;
                end
            end
            default: entry_state_d = E_IDLE;
        endcase
    end

    // Entry outputs decoded from state; a car leaving E_OPEN requests an arrival.
    always_comb begin
        entry_open  = (entry_state_q == E_OPEN);
        entry_deny  = (entry_state_q == E_DENY);
        arrival_req = entry_open && !deb_entry;
    end

    // ------------------------------------------------------------------
    // Exit barrier FSM
    // ------------------------------------------------------------------
    exit_state_t exit_state_q;
    exit_state_t exit_state_d;
    logic        exit_open;
    logic        departure_req;

    // Exit FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            exit_state_q <= X_IDLE;
        end else begin
            exit_state_q <= exit_state_d;
        end
    end

    // Exit next state: never blocked, not even when the lot reports empty.
    always_comb begin
        exit_state_d = exit_state_q;
        unique case (exit_state_q)
            X_IDLE: begin
                if (deb_exit) begin
                    exit_state_d = X_OPEN;
                end
            end
            X_OPEN: begin
                if (!deb_exit) begin
                    exit_state_d = X_IDLE;
                end
            end
            default: exit_state_d = X_IDLE;
        endcase
    end

    // Exit outputs decoded from state; a car leaving X_OPEN requests a departure.
    always_comb begin
        exit_open     = (exit_state_q == X_OPEN);
        departure_req = exit_open && !deb_exit;
    end

    // ------------------------------------------------------------------
    // Counter pulse arbitration
    // ------------------------------------------------------------------
    logic car_arrival_q;
    logic car_arrival_d;
    logic car_departure_q;
    logic car_departure_d;
    logic dep_pending_q;
    logic dep_pending_d;
    logic departure_due;

    // Arrival wins a collision; the departure is parked one cycle and sent next.
    always_comb begin
        departure_due   = departure_req | dep_pending_q;
        car_arrival_d   = arrival_req;
        car_departure_d = departure_due & ~arrival_req;
        dep_pending_d   = departure_due & arrival_req;
    end

    // Registered pulses and the deferred-departure flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            car_arrival_q   <= 1'b0;
            car_departure_q <= 1'b0;
            dep_pending_q   <= 1'b0;
        end else begin
            car_arrival_q   <= car_arrival_d;
            car_departure_q <= car_departure_d;
            dep_pending_q   <= dep_pending_d;
        end
    end

    assign gate.entry_gate_open = entry_open;
    assign gate.exit_gate_open  = exit_open;
    assign gate.entry_denied    = entry_deny;
    assign gate.car_arrival     = car_arrival_q;
    assign gate.car_departure   = car_departure_q;

endmodule
